// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared 1-bit full adder cell is walked
// LSB-first across a WIDTH-bit addition. Operands and carry-in are captured
// on the accepting edge. The sum and carry-out are presented with a
// one-cycle done pulse.

// Single-bit full adder cell shared across all bit positions.
module jfulladder (
    output logic sum,
    output logic carryout,
    input  logic a,
    input  logic b,
    input  logic carryin
);
    assign sum      = a ^ b ^ carryin;
    assign carryout = (a & b) | (a & carryin) | (b & carryin);
endmodule

// State table
//   state  | meaning
//   IDLE   | waiting for start; outputs hold the last result
//   ADD    | one bit added per clock through the carry flip-flop
//   DONE   | one-cycle done pulse; a new start here is accepted back-to-back
module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             carryout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             creg_q, creg_d;
    logic             cout_q, cout_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic             fa_sum;
    logic             fa_cout;

    jfulladder u_fa (
        .sum      (fa_sum),
        .carryout (fa_cout),
        .a        (sa_q[0]),
        .b        (sb_q[0]),
        .carryin  (creg_q)
    );

    // Next-state, datapath update and state-decoded outputs.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        y_d     = y_q;
        creg_d  = creg_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    creg_d  = carryin;
                    cnt_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                busy   = 1'b1;
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                creg_d = fa_cout;
                cnt_d  = cnt_q + CNTW'(1);
                // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
                res_d  = {fa_sum, res_q[WIDTH-1:1]};
                if (cnt_q == LAST_BIT) begin
                    y_d     = {fa_sum, res_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    creg_d  = carryin;
                    cnt_d   = '0;
                    state_d = S_ADD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            y_q     <= '0;
            creg_q  <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            y_q     <= y_d;
            creg_q  <= creg_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign y        = y_q;
    assign carryout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=8 instance for directed/random scenarios,
// WIDTH=4 instance for an exhaustive back-to-back sweep.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, co8;
    logic [7:0] y8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, co4;
    logic [3:0] y4;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] last8 = '0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8), .CNTW(6)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .carryin(cin8),
        .busy(busy8), .done(done8), .y(y8), .carryout(co8)
    );

    serial_adder_ctrl #(.WIDTH(4), .CNTW(3)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .carryin(cin4),
        .busy(busy4), .done(done4), .y(y4), .carryout(co4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble8();
        a8   = 8'($urandom);
        b8   = 8'($urandom);
        cin8 = 1'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy8); end
        n_checks++;
        if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done8); end
        n_checks++;
        if (y8 !== 8'h00) begin n_fail++; $display("FAIL reset_y got=%h exp=00", y8); end
        n_checks++;
        if (co8 !== 1'b0) begin n_fail++; $display("FAIL reset_co got=%b exp=0", co8); end
        n_checks++;
        if ({busy4, done4, co4, y4} !== 7'b0) begin
            n_fail++; $display("FAIL reset_dut4 got=%b exp=0", {busy4, done4, co4, y4});
        end
        last8 = '0;
    endtask

    // One full addition from idle: checks busy length, output stability, done pulse and result.
    task automatic add8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        logic [8:0] exp;
        exp    = {1'b0, ta} + {1'b0, tb} + 9'(tc);
        a8     = ta;
        b8     = tb;
        cin8   = tc;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        scramble8();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                n_fail++; $display("FAIL add_busy cycle=%0d got busy=%b done=%b exp busy=1 done=0", i, busy8, done8);
            end
            n_checks++;
            if ({co8, y8} !== last8) begin
                n_fail++; $display("FAIL add_hold cycle=%0d got=%h exp=%h", i, {co8, y8}, last8);
            end
            tick();
        end
        n_checks++;
        if (done8 !== 1'b1 || busy8 !== 1'b0) begin
            n_fail++; $display("FAIL add_done got done=%b busy=%b exp done=1 busy=0", done8, busy8);
        end
        n_checks++;
        if ({co8, y8} !== exp) begin
            n_fail++; $display("FAIL add_result %h+%h+%b got=%h exp=%h", ta, tb, tc, {co8, y8}, exp);
        end
        last8 = exp;
        tick();
        n_checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++; $display("FAIL add_idle got done=%b busy=%b exp 0 0", done8, busy8);
        end
    endtask

    task automatic test_basic();
        add8(8'h0F, 8'h01, 1'b0);
        add8(8'hFF, 8'h01, 1'b0);
        add8(8'hFF, 8'hFF, 1'b1);
        add8(8'h00, 8'h00, 1'b1);
    endtask

    task automatic test_start_while_busy();
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
            end else begin
                start8 = 1'b0;
                scramble8();
            end
            n_checks++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                n_fail++; $display("FAIL busy_ignore_busy cycle=%0d got busy=%b done=%b exp 1 0", i, busy8, done8);
            end
            tick();
        end
        start8 = 1'b0;
        n_checks++;
        if (done8 !== 1'b1) begin n_fail++; $display("FAIL busy_ignore_done got=%b exp=1", done8); end
        n_checks++;
        if ({co8, y8} !== 9'h046) begin
            n_fail++; $display("FAIL busy_ignore_result got=%h exp=046", {co8, y8});
        end
        last8 = 9'h046;
        tick();
    endtask

    task automatic test_back_to_back();
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (8) tick();
        n_checks++;
        if (done8 !== 1'b1 || {co8, y8} !== 9'h002) begin
            n_fail++; $display("FAIL b2b_first got done=%b res=%h exp done=1 res=002", done8, {co8, y8});
        end
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n_checks++;
        if (busy8 !== 1'b1) begin n_fail++; $display("FAIL b2b_rebusy got=%b exp=1", busy8); end
        repeat (7) begin
            n_checks++;
            if (done8 !== 1'b0 || {co8, y8} !== 9'h002) begin
                n_fail++; $display("FAIL b2b_hold got done=%b res=%h exp done=0 res=002", done8, {co8, y8});
            end
            tick();
        end
        tick();
        n_checks++;
        if (done8 !== 1'b1 || {co8, y8} !== 9'h100) begin
            n_fail++; $display("FAIL b2b_second got done=%b res=%h exp done=1 res=100", done8, {co8, y8});
        end
        last8 = 9'h100;
        tick();
    endtask

    task automatic test_reset_abort();
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({busy8, done8, co8, y8} !== 11'b0) begin
            n_fail++; $display("FAIL abort_outputs got=%b exp=0", {busy8, done8, co8, y8});
        end
        last8 = '0;
        add8(8'hAA, 8'h55, 1'b0);
        reset = 1'b1; start8 = 1'b1;
        tick();
        reset = 1'b0; start8 = 1'b0;
        n_checks++;
        if (busy8 !== 1'b0 || {co8, y8} !== 9'h000) begin
            n_fail++; $display("FAIL reset_vs_start got busy=%b res=%h exp busy=0 res=000", busy8, {co8, y8});
        end
        last8 = '0;
        tick();
        n_checks++;
        if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_vs_start_idle got=%b exp=0", busy8); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            add8(8'($urandom), 8'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_sweep4();
        int pulses;
        pulses = 0;
        for (int k = 0; k < 512; k++) begin
            logic [4:0] exp;
            logic [3:0] ta, tb;
            logic       tc;
            ta = 4'(k >> 5);
            tb = 4'(k >> 1);
            tc = 1'(k);
            exp = {1'b0, ta} + {1'b0, tb} + 5'(tc);
            a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
            tick();
            start4 = 1'b0;
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (busy4 !== 1'b1 || done4 !== 1'b0) begin
                    n_fail++; $display("FAIL sweep_busy k=%0d cycle=%0d got busy=%b done=%b exp 1 0", k, i, busy4, done4);
                end
                tick();
            end
            if (done4 === 1'b1) pulses++;
            n_checks++;
            if (done4 !== 1'b1 || {co4, y4} !== exp) begin
                n_fail++; $display("FAIL sweep_result k=%0d got done=%b res=%h exp done=1 res=%h", k, done4, {co4, y4}, exp);
            end
        end
        start4 = 1'b0;
        tick();
        n_checks++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            n_fail++; $display("FAIL sweep_end got done=%b busy=%b exp 0 0", done4, busy4);
        end
        n_checks++;
        if (pulses != 512) begin n_fail++; $display("FAIL sweep_pulses got=%0d exp=512", pulses); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_while_busy();
        test_back_to_back();
        test_reset_abort();
        test_random();
        test_sweep4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller that shares one 1-bit full adder cell (jfulladder: sum, carryout, a, b, carryin) across all bits of a WIDTH-bit addition.
- Latches two operands plus a carry-in on a start request.
- Drives the full adder LSB-first, one bit per clock, through an internal carry flip-flop.
- Presents the WIDTH-bit sum and final carry-out with a one-cycle done pulse. Used in the lab FPGA datapath where adder area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32).
- CNTW, 6, bit counter width; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- start  input  1  request to begin an addition; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, captured on the accepting edge.
- b  input  WIDTH  operand B, captured on the accepting edge.
- carryin  input  1  carry into bit 0, captured on the accepting edge.
- busy  output  1  high while bits are being processed (ADD state).
- done  output  1  one-cycle pulse: y/carryout hold a fresh result.
- y  output  WIDTH  registered sum of last completed addition.
- carryout  output  1  registered carry out of bit WIDTH-1 of last completed addition.

Behaviour:
- Reset:
  - Synchronous, active-high, one clock only; no asynchronous path.
  - state=IDLE; busy=0, done=0, y=0, carryout=0.
  - Internal shift registers, carry flip-flop and counter are cleared.
- States: IDLE, ADD, DONE. Encoding is free; no illegal-state lockup (any unused code goes to IDLE).
- IDLE:
  - busy=0, done=0.
  - On start=1: load sa<=a, sb<=b, creg<=carryin, cnt<=0, go to ADD.
- ADD:
  - busy=1. The full adder sees sa[0], sb[0], creg.
  - Each edge: shift the sum bit into the result shift register from the MSB side; shift sa and sb right by 1; creg<=full-adder carryout; cnt<=cnt+1.
  - When cnt==WIDTH-1 on an edge: y<=complete result, carryout<=full-adder carryout, go to DONE.
- DONE:
  - Lasts exactly one cycle; done=1, busy=0.
  - If start=1 in this cycle, the new request is accepted as in IDLE and the next state is ADD (back-to-back operation, no bubble). Otherwise go to IDLE.
- Latency: start sampled at edge E0; bit additions on edges E1..E_WIDTH; done high in the cycle after E_WIDTH. Throughput is one result per WIDTH+1 cycles.
- Output stability:
  - y and carryout change only on the edge entering DONE.
  - They hold their value through IDLE and through any subsequent ADD until the next completion.
- Arithmetic: {carryout, y} = a + b + carryin, modulo 2^(WIDTH+1); no overflow flag.
- start while busy: ignored. Operands are not re-sampled and the counter is not restarted.
- Input changes on a/b/carryin after the accepting edge: no effect on the operation in progress.
- reset during ADD or DONE: aborts the operation; all outputs return to reset values on that edge, including y=0 and carryout=0.
- reset and start high on the same edge: reset wins; the next state is IDLE.

Test Plan:
- WIDTH=8, reset 2 cycles -> busy=0, done=0, y=0x00, carryout=0; start a=0x0F b=0x01 carryin=0 -> busy high 8 cycles, done pulses once in the 9th cycle after start, y=0x10, carryout=0.
- a=0xFF b=0x01 carryin=0 -> y=0x00, carryout=1; then a=0xFF b=0xFF carryin=1 -> y=0xFF, carryout=1; then a=0x00 b=0x00 carryin=1 -> y=0x01, carryout=0.
- Start a=0x12 b=0x34 cin=0; at the 3rd busy cycle pulse start with a=0xFF b=0xFF, and change a/b -> request ignored, done after 8 busy cycles, y=0x46, carryout=0.
- Hold start high through the DONE cycle with a=0x80 b=0x80 cin=0 after a first add of 0x01+0x01 -> first done y=0x02; busy reasserts the cycle after DONE; second done exactly 9 cycles later, y=0x00, carryout=1.
- Start 0xAA+0x55 cin=1, assert reset at the 4th busy cycle -> next cycle busy=0, done=0, y=0x00, carryout=0; a new start afterwards of 0xAA+0x55 cin=0 completes normally with y=0xFF, carryout=0.
- Exhaustive sweep with WIDTH=4: all 512 (a,b,carryin) combinations back-to-back -> each {carryout,y} equals a+b+carryin, with exactly one done pulse per request.
